// File: rtl/uart_core_cfg.sv
// uart_core_cfg: single-clock UART with baud divisor, runtime frame format, TX/RX FIFOs, CTS/RTS.
// Define UART_PARITY_EN to build the optional parity bit (TX generation, RX check, rx_par_err).
module uart_core_cfg #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIV_WIDTH  = 16,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [DIV_WIDTH-1:0]          cfg_div,
   input  logic [3:0]                    cfg_data_bits,
   input  logic                          cfg_stop2,
   input  logic                          cfg_par_en,
   input  logic                          cfg_par_odd,
   input  logic [DATA_WIDTH-1:0]         tx_wdata,
   input  logic                          tx_wvalid,
   output logic                          tx_wready,
   output logic [DATA_WIDTH-1:0]         rx_rdata,
   output logic                          rx_rvalid,
   input  logic                          rx_rready,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          tx_busy,
   output logic                          rx_frame_err,
   output logic                          rx_par_err,
   output logic                          rx_overrun,
   output logic                          tx,
   input  logic                          rx,
   input  logic                          cts_n,
   output logic                          rts_n
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] OS_LAST  = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] OS_MID   = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]    DW4      = 4'(DATA_WIDTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] RTS_LVL  = LW'(FIFO_DEPTH - 2);

   typedef enum logic [2:0] {
      StIdle, StStart, StData, StStop, StWait
`ifdef UART_PARITY_EN
      , StParity
`endif
   } state_e;

   // Baud tick generator
   logic [DIV_WIDTH-1:0] r_div_cnt;
   logic                 w_tick;
   assign w_tick = (r_div_cnt >= cfg_div);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_div_cnt <= '0;
      else if (w_tick) r_div_cnt <= '0;
      else             r_div_cnt <= r_div_cnt + 1'b1;
   end

   logic [1:0]    r_rx_sync, r_cts_sync;
   logic          r_rts_n;
   logic          w_rx_s, w_cts_s;
   logic [LW-1:0] r_rx_level;
   assign w_rx_s  = r_rx_sync[1];
   assign w_cts_s = r_cts_sync[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_sync  <= 2'b11;
         r_cts_sync <= 2'b11;
         r_rts_n    <= 1'b1;
      end else begin
         r_rx_sync  <= {r_rx_sync[0], rx};
         r_cts_sync <= {r_cts_sync[0], cts_n};
         r_rts_n    <= (r_rx_level >= RTS_LVL);
      end
   end

   // Out-of-range data-bit counts clamp to the full word
   logic [3:0]            w_nbits;
   logic [DATA_WIDTH-1:0] w_mask;
   always_comb begin
      w_nbits = (cfg_data_bits < 4'd5 || cfg_data_bits > DW4) ? DW4 : cfg_data_bits;
      w_mask  = '0;
      for (int i = 0; i < int'(DATA_WIDTH); i++) w_mask[i] = (i < int'(w_nbits));
   end

   // TX FIFO
   logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_tx_wp, r_tx_rp;
   logic [LW-1:0]         r_tx_level;
   logic                  w_tx_push, w_tx_pop;
   state_e                r_tx_state;

   assign tx_wready = (r_tx_level != FULL_LVL);
   assign w_tx_push = tx_wvalid && tx_wready;
   assign w_tx_pop  = (r_tx_state == StIdle) && w_tick && (r_tx_level != '0) && !w_cts_s;

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx_wp    <= '0;
         r_tx_rp    <= '0;
         r_tx_level <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
         r_tx_level <= r_tx_level + LW'(w_tx_push) - LW'(w_tx_pop);
      end
   end

   // RX FIFO; a pop at full frees the slot for a same-cycle write
   logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_rx_wp, r_rx_rp;
   logic [DATA_WIDTH-1:0] r_rx_shift;
   logic                  r_rx_wr, w_rx_push, w_rx_pop;

   assign rx_rvalid = (r_rx_level != '0);
   assign rx_rdata  = r_rx_mem[r_rx_rp];
   assign w_rx_pop  = rx_rvalid && rx_rready;
   assign w_rx_push = r_rx_wr && ((r_rx_level != FULL_LVL) || w_rx_pop);

   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_wp    <= '0;
         r_rx_rp    <= '0;
         r_rx_level <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
         r_rx_level <= r_rx_level + LW'(w_rx_push) - LW'(w_rx_pop);
      end
   end

   // TX FSM
   logic [CW-1:0]         r_tx_os;
   logic [3:0]            r_tx_bit, r_tx_nbits;
   logic [DATA_WIDTH-1:0] r_tx_shift;
   logic                  r_tx_stop2, r_tx, w_tx_adv;
`ifdef UART_PARITY_EN
   logic                  r_tx_par_en, r_tx_par;
`endif
   assign w_tx_adv = w_tick && (r_tx_os == OS_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx_state  <= StIdle;
         r_tx_os     <= '0;
         r_tx_bit    <= '0;
         r_tx_nbits  <= DW4;
         r_tx_shift  <= '0;
         r_tx_stop2  <= 1'b0;
         r_tx        <= 1'b1;
`ifdef UART_PARITY_EN
         r_tx_par_en <= 1'b0;
         r_tx_par    <= 1'b0;
`endif
      end else begin
         if (w_tick && r_tx_state != StIdle) r_tx_os <= w_tx_adv ? '0 : r_tx_os + 1'b1;
         case (r_tx_state)
            StIdle: if (w_tx_pop) begin
               r_tx_state  <= StStart;
               r_tx        <= 1'b0;
               r_tx_os     <= '0;
               r_tx_shift  <= r_tx_mem[r_tx_rp] & w_mask;
               r_tx_nbits  <= w_nbits;
               r_tx_stop2  <= cfg_stop2;
`ifdef UART_PARITY_EN
               r_tx_par_en <= cfg_par_en;
               r_tx_par    <= ^(r_tx_mem[r_tx_rp] & w_mask) ^ cfg_par_odd;
`endif
            end
            StStart: if (w_tx_adv) begin
               r_tx_state <= StData;
               r_tx       <= r_tx_shift[0];
               r_tx_shift <= r_tx_shift >> 1;
               r_tx_bit   <= '0;
            end
            StData: if (w_tx_adv) begin
               if (r_tx_bit == r_tx_nbits - 1'b1) begin
                  r_tx_state <= StStop;
                  r_tx       <= 1'b1;
                  r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
                  if (r_tx_par_en) begin
                     r_tx_state <= StParity;
                     r_tx       <= r_tx_par;
                  end
`endif
               end else begin
                  r_tx       <= r_tx_shift[0];
                  r_tx_shift <= r_tx_shift >> 1;
                  r_tx_bit   <= r_tx_bit + 1'b1;
               end
            end
`ifdef UART_PARITY_EN
            StParity: if (w_tx_adv) begin
               r_tx_state <= StStop;
               r_tx       <= 1'b1;
               r_tx_bit   <= '0;
            end
`endif
            StStop: if (w_tx_adv) begin
               if (r_tx_stop2 && r_tx_bit == '0) r_tx_bit   <= 4'd1;
               else                              r_tx_state <= StIdle;
            end
            default: r_tx_state <= StIdle;
         endcase
      end
   end

   // RX FSM; sampling points are counted from the start-bit mid-point
   state_e        r_rx_state;
   logic [CW-1:0] r_rx_os;
   logic [3:0]    r_rx_bit, r_rx_nbits;
   logic          r_frame_err, r_overrun, w_rx_mid, w_rx_adv;
`ifdef UART_PARITY_EN
   logic          r_rx_par_en, r_rx_par_odd, r_par_err;
`endif
   assign w_rx_mid = w_tick && (r_rx_os == OS_MID);
   assign w_rx_adv = w_tick && (r_rx_os == OS_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_state   <= StIdle;
         r_rx_os      <= '0;
         r_rx_bit     <= '0;
         r_rx_nbits   <= DW4;
         r_rx_shift   <= '0;
         r_rx_wr      <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
         r_rx_par_en  <= 1'b0;
         r_rx_par_odd <= 1'b0;
         r_par_err    <= 1'b0;
`endif
      end else begin
         r_rx_wr     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= r_rx_wr && !w_rx_push;
`ifdef UART_PARITY_EN
         r_par_err   <= 1'b0;
`endif
         if (w_tick) r_rx_os <= w_rx_adv ? '0 : r_rx_os + 1'b1;
         case (r_rx_state)
            StIdle: if (!w_rx_s) begin
               r_rx_state   <= StStart;
               r_rx_os      <= '0;
               r_rx_nbits   <= w_nbits;
               r_rx_shift   <= '0;
`ifdef UART_PARITY_EN
               r_rx_par_en  <= cfg_par_en;
               r_rx_par_odd <= cfg_par_odd;
`endif
            end
            StStart: if (w_rx_mid) begin
               r_rx_os    <= '0;
               r_rx_bit   <= '0;
               r_rx_state <= w_rx_s ? StIdle : StData;
            end
            StData: if (w_rx_adv) begin
               r_rx_shift[r_rx_bit] <= w_rx_s;
               r_rx_bit             <= r_rx_bit + 1'b1;
               if (r_rx_bit == r_rx_nbits - 1'b1) begin
                  r_rx_state <= StStop;
`ifdef UART_PARITY_EN
                  if (r_rx_par_en) r_rx_state <= StParity;
`endif
               end
            end
`ifdef UART_PARITY_EN
            StParity: if (w_rx_adv) begin
               r_par_err  <= (w_rx_s != (^r_rx_shift ^ r_rx_par_odd));
               r_rx_state <= StStop;
            end
`endif
            StStop: if (w_rx_adv) begin
               if (w_rx_s) begin
                  r_rx_wr    <= 1'b1;
                  r_rx_state <= StIdle;
               end else begin
                  r_frame_err <= 1'b1;
                  r_rx_state  <= StWait;
               end
            end
            StWait:  if (w_rx_s) r_rx_state <= StIdle;
            default: r_rx_state <= StIdle;
         endcase
      end
   end

`ifdef UART_PARITY_EN
   assign rx_par_err = r_par_err;
`else
   logic w_unused_par;
   assign w_unused_par = cfg_par_en ^ cfg_par_odd;
   assign rx_par_err   = 1'b0;
`endif

   assign tx_level     = r_tx_level;
   assign rx_level     = r_rx_level;
   assign tx_busy      = (r_tx_state != StIdle);
   assign rx_frame_err = r_frame_err;
   assign rx_overrun   = r_overrun;
   assign tx           = r_tx;
   assign rts_n        = r_rts_n;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg: reset, 8N1 TX waveform, loopback, framing/parity errors,
// RX fill with RTS and overrun, CTS gating and asynchronous reset mid-frame.
module tb_uart_core_cfg;
   localparam int OS = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] cfg_div = '0;
   logic [3:0]  cfg_data_bits = 4'd8;
   logic        cfg_stop2 = 1'b0, cfg_par_en = 1'b0, cfg_par_odd = 1'b0;
   logic [7:0]  tx_wdata = '0;
   logic        tx_wvalid = 1'b0, rx_rready = 1'b0, cts_n = 1'b1;
   logic        rx_drv = 1'b1, loopback = 1'b0;
   logic        tx_wready, rx_rvalid, tx_busy, rx_frame_err, rx_par_err, rx_overrun;
   logic        tx, rx_w, rts_n;
   logic [7:0]  rx_rdata;
   logic [4:0]  tx_level, rx_level;

   int n_vec = 0, n_bad = 0;
   int n_ferr = 0, n_perr = 0, n_ovr = 0;

   assign rx_w = loopback ? tx : rx_drv;

   uart_core_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DIV_WIDTH(16), .OVERSAMPLE(OS)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits),
      .cfg_stop2(cfg_stop2), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd),
      .tx_wdata(tx_wdata), .tx_wvalid(tx_wvalid), .tx_wready(tx_wready),
      .rx_rdata(rx_rdata), .rx_rvalid(rx_rvalid), .rx_rready(rx_rready),
      .tx_level(tx_level), .rx_level(rx_level), .tx_busy(tx_busy),
      .rx_frame_err(rx_frame_err), .rx_par_err(rx_par_err), .rx_overrun(rx_overrun),
      .tx(tx), .rx(rx_w), .cts_n(cts_n), .rts_n(rts_n)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_frame_err) n_ferr++;
      if (rx_par_err)   n_perr++;
      if (rx_overrun)   n_ovr++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      @(negedge clk);
      tx_wdata  = d;
      tx_wvalid = 1'b1;
      @(negedge clk);
      tx_wvalid = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      @(negedge clk);
      check(tag, rx_rdata, exp);
      rx_rready = 1'b1;
      @(negedge clk);
      rx_rready = 1'b0;
   endtask

   task automatic drive_bit(input logic b);
      rx_drv = b;
      repeat (OS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input logic par_en,
                             input logic par_bit, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < nb; i++) drive_bit(d[i]);
      if (par_en) drive_bit(par_bit);
      drive_bit(stop_bit);
      rx_drv = 1'b1;
      repeat (24) @(negedge clk);
   endtask

   initial begin
      logic [9:0] frame_a5;
      logic [7:0] b;
      int         f0, p0, o0, n_low;

      // Reset state
      #12;
      check("rst_tx", tx, 1);
      check("rst_rts", rts_n, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_txlvl", tx_level, 0);
      check("rst_rxlvl", rx_level, 0);
      check("rst_rvalid", rx_rvalid, 0);
      check("rst_errs", {rx_frame_err, rx_par_err, rx_overrun}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rts_after_rst", rts_n, 0);

      // 8N1 TX of 0xA5 at cfg_div=0
      cts_n = 1'b0;
      repeat (4) @(negedge clk);
      push(8'hA5);
      check("a5_level_pushed", tx_level, 1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (tx == 1'b0) break;
      end
      check("a5_start", tx, 0);
      check("a5_popped", tx_level, 0);
      frame_a5 = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 10; i++) begin
         repeat ((i == 0) ? 8 : 16) @(posedge clk);
         #1;
         check($sformatf("a5_bit%0d", i), tx, frame_a5[i]);
      end
      repeat (7) @(posedge clk); #1;
      check("a5_busy_159", tx_busy, 1);
      @(posedge clk); #1;
      check("a5_busy_160", tx_busy, 0);

      // Loopback 7 data bits, 2 stop, cfg_div=3
      @(negedge clk);
      cfg_div = 16'd3; cfg_data_bits = 4'd7; cfg_stop2 = 1'b1; loopback = 1'b1;
      f0 = n_ferr;
      push(8'h7F);
      push(8'h00);
      push(8'h55);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (rx_level == 5'd3) break;
      end
      check("lb_level", rx_level, 3);
      pop_check("lb_w0", 8'h7F);
      pop_check("lb_w1", 8'h00);
      pop_check("lb_w2", 8'h55);
      check("lb_no_ferr", n_ferr - f0, 0);
      repeat (300) @(negedge clk);
      loopback = 1'b0;
      cfg_div = '0; cfg_data_bits = 4'd8; cfg_stop2 = 1'b0;
      repeat (4) @(negedge clk);

      // Framing error then a good frame
      f0 = n_ferr;
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
      check("ferr_pulse", n_ferr - f0, 1);
      check("ferr_level", rx_level, 0);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      check("good_level", rx_level, 1);
      check("good_no_ferr", n_ferr - f0, 1);
      pop_check("good_data", 8'h3C);

      // Fill RX FIFO, RTS threshold, overrun
      for (int i = 0; i < 16; i++) begin
         b = 8'h40 + 8'(i);
         send_frame(b, 8, 1'b0, 1'b0, 1'b1);
         check($sformatf("fill_level%0d", i), rx_level, i + 1);
         if (i == 12) check("rts_lvl13", rts_n, 0);
         if (i == 13) check("rts_lvl14", rts_n, 1);
      end
      check("rts_full", rts_n, 1);
      o0 = n_ovr;
      send_frame(8'h99, 8, 1'b0, 1'b0, 1'b1);
      check("ovr_pulse", n_ovr - o0, 1);
      check("ovr_level", rx_level, 16);
      check("ovr_head", rx_rdata, 8'h40);
      for (int i = 0; i < 16; i++) begin
         b = 8'h40 + 8'(i);
         pop_check($sformatf("drain%0d", i), b);
      end
      repeat (3) @(negedge clk);
      check("drain_level", rx_level, 0);
      check("drain_rts", rts_n, 0);

`ifdef UART_PARITY_EN
      // Even parity on 0x03: parity bit should be 0
      cfg_par_en = 1'b1; cfg_par_odd = 1'b0;
      p0 = n_perr;
      send_frame(8'h03, 8, 1'b1, 1'b1, 1'b1);
      check("par_bad_pulse", n_perr - p0, 1);
      check("par_bad_level", rx_level, 1);
      pop_check("par_bad_data", 8'h03);
      send_frame(8'h03, 8, 1'b1, 1'b0, 1'b1);
      check("par_ok_nopulse", n_perr - p0, 1);
      pop_check("par_ok_data", 8'h03);
      cfg_par_en = 1'b0;
`else
      p0 = n_perr;
      check("par_tied", n_perr - p0, 0);
`endif

      // CTS gating and async reset mid-frame
      cts_n = 1'b1;
      repeat (4) @(negedge clk);
      push(8'h11);
      n_low = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx == 1'b0) n_low++;
      end
      check("cts_hold_tx", n_low, 0);
      check("cts_hold_busy", tx_busy, 0);
      check("cts_hold_level", tx_level, 1);
      cts_n = 1'b0;
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         if (tx == 1'b0) break;
      end
      check("cts_start", tx, 0);
      repeat (40) @(posedge clk); #1;
      check("mid_bit1", tx, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_tx", tx, 1);
      check("arst_txlvl", tx_level, 0);
      check("arst_busy", tx_busy, 0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
